ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch front end: reads the current PC from the pc register, issues instruction-memory reads over a valid/ready request and valid response interface, and queues fetched words for decode.
- Drives next_pc back into the pc register every cycle: hold, increment by 4, or redirect target.
- Sits between pc and decode in the MIPS32 datapath; handles branch/jump redirects by flushing queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, value next_pc presents while rst is high; must equal the pc register reset value.
- QDEPTH, 2, instruction queue entries (power of 2, at least 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pc_in  in  32  current PC from the pc register
- next_pc  out  32  next PC to the pc register, combinational
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, equals pc_in
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response word valid, one per accepted request
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  redirect target
- inst_valid  out  1  queue head valid
- inst_data  out  32  queue head instruction
- inst_pc  out  32  queue head PC
- inst_ready  in  1  decode consumes head
- busy  out  1  request in flight (state S_WAIT or S_DROP)

Behaviour:
- Reset (async, rst=1):
  - state=S_REQ, queue count=0, pointers=0.
  - All outputs 0 except next_pc=RESET_PC.
- FSM states:
  - S_REQ: no request in flight.
  - S_WAIT: one request in flight; response is kept.
  - S_DROP: one request in flight; response is discarded.
- Maximum one outstanding request. Responses arrive at least 1 cycle after acceptance.
- imem_req_valid = (state==S_REQ) and !redirect_valid and (count < QDEPTH) and !rst.
  - count reserves space for the in-flight word, so the queue never overflows.
- Request handshake:
  - Accepted when imem_req_valid and imem_req_ready.
  - On acceptance: next_pc=pc_in+4 (mod 2^32; 0xFFFFFFFC wraps to 0), latch req_pc=pc_in, go to S_WAIT.
  - Otherwise next_pc=pc_in (hold).
- Request address is held stable while valid is high and ready is low, because pc_in is held.
- S_WAIT with imem_rsp_valid:
  - Push {req_pc, imem_rsp_data} into the queue.
  - Go to S_REQ. A new request may issue the next cycle.
- S_DROP with imem_rsp_valid: discard the word, go to S_REQ.
- imem_rsp_valid in S_REQ is ignored (protocol error; no state change).
- Redirect has highest priority:
  - next_pc=redirect_pc; no request issued that cycle; queue flushed (count=0).
  - S_WAIT goes to S_DROP; S_REQ stays S_REQ; S_DROP stays S_DROP.
  - If a response arrives in the same cycle as a redirect, it is discarded and state goes to S_REQ.
- Queue:
  - Circular buffer; inst_valid=(count!=0); head fields are registered storage.
  - Pop on inst_valid and inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - A pop in the same cycle as a redirect is a don't-care (flush wins).
- Throughput: one instruction per 2 cycles with single-cycle memory (request, then response). Pipelining beyond that is out of scope.
- Reset mid-operation: in-flight request abandoned; a response arriving after rst deasserts is ignored (state S_REQ).

Decomposition:
- Package mips_fetch_pkg:
  - fetch_state_t enum (S_REQ, S_WAIT, S_DROP).
  - INST_W=32, PC_INC=32'd4.
- One sub-module: ifetch_queue (parameterised FIFO with push, pop and flush, exposing count).

Test Plan:
1. Reset with rst=1 for 2 cycles: next_pc=0x00000000, imem_req_valid=0, inst_valid=0, busy=0.
2. Release rst, memory ready=1 with 1-cycle response:
   - Fetches 0x0, 0x4 and 0x8 return 0x20080001, 0x20090002, 0x01095020.
   - inst_pc/inst_data pairs appear in order.
   - next_pc pattern is +4 on each accept cycle and hold otherwise.
3. Hold inst_ready=0:
   - Exactly QDEPTH=2 entries fill.
   - imem_req_valid drops to 0 and next_pc holds at 0x8.
   - Asserting inst_ready resumes fetch at 0x8.
4. Redirect to 0x00001000 while in S_WAIT:
   - Queue flushed; in-flight response (from 0x4) dropped.
   - next_pc=0x00001000.
   - First queued entry has inst_pc=0x00001000.
5. pc_in=0xFFFFFFFC accepted: next_pc=0x00000000; queued inst_pc=0xFFFFFFFC.
6. Assert rst while busy=1, then deliver imem_rsp_valid after release: response ignored, inst_valid=0, next fetch at pc_in=0x0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package mips_fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - circular instruction queue with push, pop and flush
import mips_fetch_pkg::*;

module ifetch_queue #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_entry;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is cleared on reset so the head fields read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch FSM driving next_pc, imem requests and the decode queue
import mips_fetch_pkg::*;

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        busy
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          accept, push;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    // A response coinciding with a redirect still retires the request, so it goes straight to S_REQ.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_in;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid)      state_d = S_REQ;
                else if (redirect_valid) state_d = S_DROP;
            end
            S_DROP: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Requests only issue with nothing in flight, so count alone guarantees room for the word.
    always_comb begin
        imem_req_valid = (state_q == S_REQ) && !redirect_valid && (count < CW'(QDEPTH)) && !rst;
        accept         = imem_req_valid && imem_req_ready;
        push           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
        busy           = (state_q != S_REQ);
        if (rst)                 next_pc = RESET_PC;
        else if (redirect_valid) next_pc = redirect_pc;
        else if (accept)         next_pc = pc_in + PC_INC;
        else                     next_pc = pc_in;
    end

    assign imem_req_addr = pc_in;

    ifetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry ('{pc: req_pc_q, data: imem_rsp_data}),
        .pop        (inst_ready),
        .head       (head),
        .count      (count)
    );

    assign inst_valid = (count != '0);
    assign inst_data  = head.data;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    localparam logic [31:0] W0 = 32'h20080001;
    localparam logic [31:0] W1 = 32'h20090002;
    localparam logic [31:0] W2 = 32'h01095020;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        busy;

    logic        mem_auto;
    logic        man_valid;
    logic [31:0] man_data;
    logic        acc_q;
    logic [31:0] acc_addr_q;

    int total;
    int bad;

    ifetch_unit #(.RESET_PC(32'h00000000), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   return W0;
            32'h4:   return W1;
            32'h8:   return W2;
            default: return addr ^ 32'hA5A50000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_in <= 32'h0;
        else     pc_in <= next_pc;
    end

    // Single-cycle memory: answers in the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= 1'b0;
            acc_addr_q <= 32'h0;
        end else begin
            acc_q      <= imem_req_valid && imem_req_ready;
            acc_addr_q <= imem_req_addr;
        end
    end

    assign imem_rsp_valid = mem_auto ? acc_q : man_valid;
    assign imem_rsp_data  = mem_auto ? mem_word(acc_addr_q) : man_data;

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; inst_ready = 1'b0;
        man_valid = 1'b0; man_data = 32'h0; mem_auto = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        man_valid = 1'b0; man_data = 32'h0; mem_auto = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (next_pc !== 32'h0) begin bad++; $display("FAIL rst_next_pc got=%h exp=%h", next_pc, 32'h0); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("FAIL rst_head got=%h/%h exp=0/0", inst_pc, inst_data); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b1; mem_auto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*k)) begin bad++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, 32'(4*k)); end
            total++; if (next_pc !== 32'(4*k+4)) begin bad++; $display("FAIL stream_next_acc k=%0d got=%h exp=%h", k, next_pc, 32'(4*k+4)); end
            if (k > 0) begin
                total++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(k-1)) || inst_data !== exp_w[k-1]) begin bad++; $display("FAIL stream_inst k=%0d got=%b/%h/%h exp=1/%h/%h", k, inst_valid, inst_pc, inst_data, 32'(4*(k-1)), exp_w[k-1]); end
            end else begin
                total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", inst_valid); end
            end
            @(negedge clk); #1;
            total++; if (imem_req_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stream_wait k=%0d got=%b/%b exp=0/1", k, imem_req_valid, busy); end
            total++; if (next_pc !== 32'(4*k+4)) begin bad++; $display("FAIL stream_next_hold k=%0d got=%h exp=%h", k, next_pc, 32'(4*k+4)); end
            @(negedge clk);
        end
        #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== W2) begin bad++; $display("FAIL stream_last got=%b/%h/%h exp=1/8/%h", inst_valid, inst_pc, inst_data, W2); end
    endtask

    task automatic test_fill();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL fill_one got=%b/%b/%h exp=1/1/4", inst_valid, imem_req_valid, imem_req_addr); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL fill_full_req got=%b exp=0", imem_req_valid); end
        total++; if (next_pc !== 32'h8) begin bad++; $display("FAIL fill_full_next got=%h exp=8", next_pc); end
        total++; if (inst_pc !== 32'h0 || inst_data !== W0) begin bad++; $display("FAIL fill_head got=%h/%h exp=0/%h", inst_pc, inst_data, W0); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (imem_req_valid !== 1'b0 || next_pc !== 32'h8 || inst_pc !== 32'h0) begin bad++; $display("FAIL fill_stall got=%b/%h/%h exp=0/8/0", imem_req_valid, next_pc, inst_pc); end
        inst_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (inst_pc !== 32'h4 || inst_data !== W1) begin bad++; $display("FAIL fill_pop got=%h/%h exp=4/%h", inst_pc, inst_data, W1); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || next_pc !== 32'hC) begin bad++; $display("FAIL fill_resume got=%b/%h/%h exp=1/8/c", imem_req_valid, imem_req_addr, next_pc); end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b0;
        @(negedge clk);
        man_valid = 1'b1; man_data = W0;
        @(negedge clk);
        man_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL redir_pre got=%b/%h/%h exp=1/0/4", inst_valid, inst_pc, imem_req_addr); end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h00001000; #1;
        total++; if (busy !== 1'b1 || imem_req_valid !== 1'b0 || next_pc !== 32'h00001000) begin bad++; $display("FAIL redir_cycle got=%b/%b/%h exp=1/0/1000", busy, imem_req_valid, next_pc); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b0 || busy !== 1'b1 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_drop got=%b/%b/%b exp=0/1/0", inst_valid, busy, imem_req_valid); end
        total++; if (next_pc !== 32'h00001000) begin bad++; $display("FAIL redir_hold got=%h exp=1000", next_pc); end
        @(negedge clk);
        man_valid = 1'b1; man_data = W1;
        @(negedge clk);
        man_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL redir_discard got=%b/%b exp=0/0", inst_valid, busy); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00001000 || next_pc !== 32'h00001004) begin bad++; $display("FAIL redir_refetch got=%b/%h/%h exp=1/1000/1004", imem_req_valid, imem_req_addr, next_pc); end
        @(negedge clk);
        man_valid = 1'b1; man_data = 32'h12345678;
        @(negedge clk);
        man_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h00001000 || inst_data !== 32'h12345678) begin bad++; $display("FAIL redir_first got=%b/%h/%h exp=1/1000/12345678", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b0;
        @(negedge clk);
        man_valid = 1'b1; man_data = W0;
        redirect_valid = 1'b1; redirect_pc = 32'h00002000; #1;
        total++; if (next_pc !== 32'h00002000 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_rsp_cycle got=%h/%b exp=2000/0", next_pc, imem_req_valid); end
        @(negedge clk);
        man_valid = 1'b0; redirect_valid = 1'b0; #1;
        total++; if (busy !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL redir_rsp_state got=%b/%b exp=0/0", busy, inst_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00002000 || next_pc !== 32'h00002004) begin bad++; $display("FAIL redir_rsp_next got=%b/%h/%h exp=1/2000/2004", imem_req_valid, imem_req_addr, next_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC; #1;
        total++; if (next_pc !== 32'hFFFFFFFC || imem_req_valid !== 1'b0) begin bad++; $display("FAIL wrap_redir got=%h/%b exp=fffffffc/0", next_pc, imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC || next_pc !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h/%h exp=1/fffffffc/0", imem_req_valid, imem_req_addr, next_pc); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFFFFFC || inst_data !== 32'h5A5AFFFC) begin bad++; $display("FAIL wrap_inst got=%b/%h/%h exp=1/fffffffc/5a5afffc", inst_valid, inst_pc, inst_data); end
        total++; if (imem_req_addr !== 32'h0 || next_pc !== 32'h4) begin bad++; $display("FAIL wrap_after got=%h/%h exp=0/4", imem_req_addr, next_pc); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        imem_req_ready = 1'b1; inst_ready = 1'b0; mem_auto = 1'b0;
        @(negedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rbusy_pre got=%b exp=1", busy); end
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0 || next_pc !== 32'h0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rbusy_async got=%b/%h/%b/%b exp=0/0/0/0", busy, next_pc, imem_req_valid, inst_valid); end
        @(negedge clk);
        rst = 1'b0; imem_req_ready = 1'b0; man_valid = 1'b1; man_data = 32'hDEADBEEF; #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || next_pc !== 32'h0) begin bad++; $display("FAIL rbusy_release got=%b/%h/%h exp=1/0/0", imem_req_valid, imem_req_addr, next_pc); end
        @(negedge clk);
        man_valid = 1'b0; imem_req_ready = 1'b1; #1;
        total++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rbusy_ignored got=%b/%b exp=0/0", inst_valid, busy); end
        total++; if (imem_req_addr !== 32'h0 || next_pc !== 32'h4) begin bad++; $display("FAIL rbusy_fetch got=%h/%h exp=0/4", imem_req_addr, next_pc); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
